// File: rtl/send_frame_packer.sv
// Packs 32-bit modulated samples into framed bytes: A5 5A, sequence, FRAME_LEN samples MSB first, checksum.
// Samples are buffered in a FIFO so the byte sink may stall without loss until the FIFO fills.
module send_frame_packer #(
  parameter int          FRAME_LEN  = 16,
  parameter int          FIFO_DEPTH = 64,
  parameter logic [7:0]  HDR0       = 8'hA5,
  parameter logic [7:0]  HDR1       = 8'h5A
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   sample_in,
  input  logic                          sample_vld,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [7:0]                    frame_seq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          busy,
  output logic [2:0]                    fsm_state
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int SCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_SEQ  = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  state_t           state;
  logic [1:0]       byte_idx;
  logic [SCW-1:0]   sample_cnt;
  logic [7:0]       csum;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             full;
  logic             wr_en;
  logic             drop;
  logic             fire;
  logic             pop;
  logic             last_sample;
  logic [7:0]       csum_next;
  logic [31:0]      head;
  logic [31:0]      next_head;

  // Handshake: a byte transfers on a rising edge where tx_valid & tx_ready are both high.
  // tx_valid and tx_data come straight from flops; tx_data only changes after a transfer,
  // so it holds steady through any stall, and tx_valid never depends on tx_ready in the same cycle.
  assign fire        = tx_valid && tx_ready;
  assign full        = (fifo_level == LW'(FIFO_DEPTH));
  assign wr_en       = sample_vld && !full;
  assign drop        = sample_vld && full;
  assign pop         = fire && (state == ST_DATA) && (byte_idx == 2'd3);
  assign last_sample = (sample_cnt == SCW'(FRAME_LEN - 1));
  assign csum_next   = csum + tx_data;
  assign head        = mem[rd_ptr];
  assign next_head   = mem[rd_ptr + AW'(1)];
  assign busy        = (state != ST_IDLE);
  assign fsm_state   = state;

  function automatic logic [7:0] pick(input logic [31:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = s[31:24];
      2'd1:    b = s[23:16];
      2'd2:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction

  // Storage array carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      frame_seq  <= 8'h00;
      byte_idx   <= 2'd0;
      sample_cnt <= '0;
      csum       <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          csum       <= 8'h00;
          byte_idx   <= 2'd0;
          sample_cnt <= '0;
          // A frame starts only once every sample it needs is already buffered.
          if (fifo_level >= LW'(FRAME_LEN)) begin
            state    <= ST_HDR0;
            tx_valid <= 1'b1;
            tx_data  <= HDR0;
          end
        end
        ST_HDR0: if (fire) begin
          state   <= ST_HDR1;
          tx_data <= HDR1;
        end
        ST_HDR1: if (fire) begin
          state   <= ST_SEQ;
          tx_data <= frame_seq;
        end
        ST_SEQ: if (fire) begin
          csum    <= csum_next;
          state   <= ST_DATA;
          tx_data <= pick(head, 2'd0);
        end
        ST_DATA: if (fire) begin
          csum <= csum_next;
          if (byte_idx == 2'd3) begin
            byte_idx <= 2'd0;
            if (last_sample) begin
              state   <= ST_CSUM;
              tx_data <= csum_next;
            end else begin
              // Head is being popped this edge, so the next byte comes from the following entry.
              sample_cnt <= sample_cnt + SCW'(1);
              tx_data    <= pick(next_head, 2'd0);
            end
          end else begin
            byte_idx <= byte_idx + 2'd1;
            tx_data  <= pick(head, byte_idx + 2'd1);
          end
        end
        ST_CSUM: if (fire) begin
          state     <= ST_IDLE;
          tx_valid  <= 1'b0;
          tx_data   <= 8'h00;
          frame_seq <= frame_seq + 8'd1;
        end
        default: begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_send_frame_packer.sv
// Self-checking bench for send_frame_packer: a frame model fills an expected byte queue,
// a negedge monitor pops and compares every accepted byte and checks stall stability.
module tb_send_frame_packer;

  localparam int FRAME_LEN  = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  localparam int RDY_ON     = 0;
  localparam int RDY_TOGGLE = 1;
  localparam int RDY_OFF    = 2;
  localparam int RDY_RAND   = 3;

  localparam logic [2:0] S_DATA = 3'd4;

  logic          clk;
  logic          rst;
  logic [31:0]   sample_in;
  logic          sample_vld;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    frame_seq;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          ovf_clr;
  logic          busy;
  logic [2:0]    fsm_state;

  send_frame_packer #(
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .HDR0      (8'hA5),
    .HDR1      (8'h5A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_in (sample_in),
    .sample_vld(sample_vld),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .frame_seq (frame_seq),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ready_mode = RDY_ON;
  logic [7:0]  exp_q[$];
  logic [31:0] pend_q[$];
  logic [7:0]  model_seq = 8'h00;
  logic [7:0]  last_byte = 8'h00;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          stall_cnt = 0;

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        RDY_ON:     tx_ready = 1'b1;
        RDY_TOGGLE: tx_ready = ~tx_ready;
        RDY_OFF:    tx_ready = 1'b0;
        default:    tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- model ----------------
  task automatic model_add(input logic [31:0] s);
    logic [7:0] sum;
    logic [7:0] b;
    pend_q.push_back(s);
    if (pend_q.size() == FRAME_LEN) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(model_seq);
      sum = model_seq;
      for (int i = 0; i < FRAME_LEN; i++) begin
        for (int k = 3; k >= 0; k--) begin
          b = 8'((pend_q[i] >> (8 * k)) & 32'hFF);
          exp_q.push_back(b);
          sum = sum + b;
        end
      end
      exp_q.push_back(sum);
      model_seq = model_seq + 8'd1;
      pend_q.delete();
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    pend_q.delete();
    model_seq = 8'h00;
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at #1 after a rising edge; the sample is taken on the edge in between.
  task automatic drive_sample(input logic [31:0] s, input bit keep);
    sample_in  = s;
    sample_vld = 1'b1;
    @(posedge clk);
    #1;
    sample_vld = 1'b0;
    if (keep) model_add(s);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL %s drain: %0d bytes pending busy=%b, required 0 pending busy=0", name, exp_q.size(), busy);
    else
      n_pass++;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data)
          $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_data);
        else
          n_pass++;
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_byte: got unexpected %h, required no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e)
            $display("FAIL stream_byte: got %h, required %h", tx_data, e);
          else
            n_pass++;
        end
        last_byte = tx_data;
      end
      prev_stall = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
      if (prev_stall) stall_cnt++;
      prev_data = tx_data;
    end
  end

  // ---------------- tests ----------------
  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || frame_seq !== 8'h00 ||
        fifo_level !== '0 || overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s: valid=%b data=%h seq=%h level=%0d ovf=%b busy=%b, required all zero",
               name, tx_valid, tx_data, frame_seq, fifo_level, overflow, busy);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check_idle_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset_release");
  endtask

  task automatic test_basic();
    ready_mode = RDY_ON;
    for (int i = 1; i <= 16; i++) drive_sample(32'(i), 1'b1);
    n_checks++;
    if (fifo_level !== LW'(16) || tx_valid !== 1'b0)
      $display("FAIL basic_level: level=%0d valid=%b, required 16 and 0", fifo_level, tx_valid);
    else
      n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1)
      $display("FAIL basic_latency: valid=%b data=%h busy=%b, required 1 a5 1", tx_valid, tx_data, busy);
    else
      n_pass++;
    wait_drain(300, "basic");
    n_checks++;
    if (last_byte !== 8'h88 || frame_seq !== 8'h01 || busy !== 1'b0)
      $display("FAIL basic_end: csum=%h seq=%h busy=%b, required 88 01 0", last_byte, frame_seq, busy);
    else
      n_pass++;
  endtask

  task automatic test_toggle_ready();
    int stalls_before = stall_cnt;
    ready_mode = RDY_TOGGLE;
    for (int i = 1; i <= 16; i++) drive_sample(32'(i), 1'b1);
    wait_drain(400, "toggle");
    n_checks++;
    if (stall_cnt - stalls_before < 60 || last_byte !== 8'h89)
      $display("FAIL toggle: stalls=%0d csum=%h, required >=60 and 89", stall_cnt - stalls_before, last_byte);
    else
      n_pass++;
    ready_mode = RDY_ON;
  endtask

  task automatic test_all_ones();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_flush();
    ready_mode = RDY_ON;
    for (int i = 0; i < 16; i++) drive_sample(32'hFFFF_FFFF, 1'b1);
    wait_drain(300, "all_ones");
    n_checks++;
    if (last_byte !== 8'hC0)
      $display("FAIL all_ones_csum: got %h, required c0", last_byte);
    else
      n_pass++;
  endtask

  task automatic test_seq_wrap();
    logic [7:0] seq0 = frame_seq;
    ready_mode = RDY_ON;
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < 16; i++) drive_sample($urandom, 1'b1);
      wait_drain(300, "seq_wrap");
    end
    n_checks++;
    if (frame_seq !== seq0 + 8'd1)
      $display("FAIL seq_wrap: seq=%h, required %h", frame_seq, seq0 + 8'd1);
    else
      n_pass++;
  endtask

  task automatic test_overflow();
    ready_mode = RDY_OFF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) drive_sample(32'h0100_0000 + 32'(i), 1'b1);
    drive_sample(32'hDEAD_0065, 1'b0);
    n_checks++;
    if (fifo_level !== LW'(64) || overflow !== 1'b1)
      $display("FAIL ovf_set: level=%0d ovf=%b, required 64 1", fifo_level, overflow);
    else
      n_pass++;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clr: ovf=%b, required 0", overflow);
    else
      n_pass++;
    ovf_clr = 1'b1;
    drive_sample(32'hDEAD_0066, 1'b0);
    ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || fifo_level !== LW'(64))
      $display("FAIL ovf_set_wins: ovf=%b level=%0d, required 1 64", overflow, fifo_level);
    else
      n_pass++;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    ready_mode = RDY_ON;
    wait_drain(1000, "overflow");
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    ready_mode = RDY_RAND;
    for (int i = 0; i < 16; i++) drive_sample($urandom, 1'b1);
    while (fsm_state !== S_DATA && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || fifo_level !== '0 || busy !== 1'b0 || cyc >= 100)
      $display("FAIL reset_mid: valid=%b level=%0d busy=%b wait=%0d, required 0 0 0 <100",
               tx_valid, fifo_level, busy, cyc);
    else
      n_pass++;
    model_flush();
    @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = RDY_RAND;
    for (int i = 0; i < 16; i++) drive_sample($urandom, 1'b1);
    wait_drain(600, "after_reset");
    n_checks++;
    if (frame_seq !== 8'h01)
      $display("FAIL after_reset_seq: seq=%h, required 01", frame_seq);
    else
      n_pass++;
  endtask

  task automatic test_back_to_back();
    ready_mode = RDY_RAND;
    for (int i = 0; i < 48; i++) drive_sample($urandom, 1'b1);
    wait_drain(1500, "back_to_back");
    ready_mode = RDY_ON;
  endtask

  initial begin
    rst        = 1'b0;
    sample_in  = 32'h0;
    sample_vld = 1'b0;
    ovf_clr    = 1'b0;
    test_reset();
    test_basic();
    test_toggle_ready();
    test_all_ones();
    test_seq_wrap();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
